// File: rtl/seq_pattern_gen.sv
// ============================================================================
// Module   : seq_pattern_gen
// Brief    : Serial pattern source with repeat and golden overlapping-match
//            Moore-detector model driving exp_z.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_pattern_gen #(
  parameter int                    WIDTH      = 20,
  parameter int                    CNT_W      = 8,
  parameter int                    TARGET_LEN = 4,
  parameter logic [TARGET_LEN-1:0] TARGET     = 4'b1101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             exp_z
);

  localparam int BIT_W  = $clog2(WIDTH + 1);
  localparam int SEEN_W = $clog2(TARGET_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_hold;
  logic [WIDTH-1:0]      r_shift;
  logic [BIT_W-1:0]      r_bitcnt;
  logic [CNT_W-1:0]      r_rep;
  logic [TARGET_LEN-1:0] r_hist;
  logic [SEEN_W-1:0]     r_seen;
  logic                  r_x;
  logic                  r_x_valid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_exp_z;

  logic [TARGET_LEN:0]   w_cat;
  logic [TARGET_LEN-1:0] w_hist_next;
  logic                  w_full;
  logic                  w_match;

  // History including the bit currently on x; r_seen counts bits already in r_hist.
  assign w_cat       = {r_hist, r_x};
  assign w_hist_next = w_cat[TARGET_LEN-1:0];
  assign w_full      = (r_seen >= SEEN_W'(TARGET_LEN - 1));
  assign w_match     = w_full && (w_hist_next == TARGET);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_rep     <= '0;
      r_hist    <= '0;
      r_seen    <= '0;
      r_x       <= 1'b0;
      r_x_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_exp_z   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (r_x_valid) begin
        r_hist  <= w_hist_next;
        r_exp_z <= w_match;
        if (!w_full) r_seen <= r_seen + SEEN_W'(1);
      end else begin
        r_exp_z <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_hold    <= pattern;
            r_x       <= pattern[WIDTH-1];
            r_shift   <= pattern << 1;
            r_bitcnt  <= BIT_W'(WIDTH - 1);
            r_rep     <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
            r_hist    <= '0;
            r_seen    <= '0;
            r_x_valid <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (r_bitcnt != '0) begin
            r_x      <= r_shift[WIDTH-1];
            r_shift  <= r_shift << 1;
            r_bitcnt <= r_bitcnt - BIT_W'(1);
          end else if (r_rep > CNT_W'(1)) begin
            // Next pass starts on the very next cycle, no gap.
            r_x      <= r_hold[WIDTH-1];
            r_shift  <= r_hold << 1;
            r_bitcnt <= BIT_W'(WIDTH - 1);
            r_rep    <= r_rep - CNT_W'(1);
          end else begin
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign x       = r_x;
  assign x_valid = r_x_valid;
  assign busy    = r_busy;
  assign done    = r_done;
  assign exp_z   = r_exp_z;

endmodule

`default_nettype wire
